qcw_burst_sequencer: RTL and testbench
======================================

Name: qcw_burst_sequencer

Overview:
- Sequences one QCW burst around the phase-tracking PLL that drives the bridge gate.
- Per burst: open-loop kick at a fixed startup frequency, then hand-off to PLL tracking with the feedback-loss watchdog armed, then a graceful stop on a low drive edge.
- Sits between the interrupter/trigger logic and the PLL/gate-drive path.
- Owns drive_out selection, the PLL period preload and enable, and the fault latch.

Parameters:
- CNT_W, 16, width of half-period, kick-cycle and watchdog counters.
- BURST_W, 24, width of burst length counter (clk cycles).
- KICK_HALF, 350, open-loop half period in clk cycles (period 700).
- KICK_CYCLES, 4, number of full open-loop periods before hand-off.
- FB_TIMEOUT, 2000, clk cycles without a feedback rising edge in TRACK before fault.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  burst request; level sampled each clk; acted on only in IDLE.
- burst_len  in  BURST_W  burst length in clk cycles; latched when start is accepted.
- abort  in  1  request graceful stop.
- fault_clr  in  1  clears a latched fault.
- feedback_in  in  1  asynchronous primary-current zero-cross comparator.
- pll_out  in  1  PLL output clock.
- pll_enable  out  1  PLL run enable.
- pll_load  out  1  one-cycle preload strobe to PLL.
- pll_period  out  CNT_W  preload value; constant 2*KICK_HALF.
- drive_out  out  1  registered gate drive.
- busy  out  1  high in KICK, TRACK, STOP or DONE.
- done  out  1  one-cycle pulse at burst completion.
- fault  out  1  latched feedback-loss fault.
- state  out  3  encoding: IDLE=0, KICK=1, TRACK=2, STOP=3, DONE=4, FAULT=5.

Behaviour:
- Reset (async): state=IDLE; all counters 0; all outputs 0; pll_period=2*KICK_HALF. drive_out falls immediately, even mid-burst.
- feedback_in passes through a 2-FF synchronizer plus a rising-edge detect, so a detected edge lags the input by 3 clk.
- IDLE:
  - start=1 with burst_len!=0: next edge enters KICK, latches burst_len, pll_load=1 for that cycle.
  - start=1 with burst_len=0: ignored; no done pulse.
- KICK:
  - Internal source is high for KICK_HALF clocks, then low for KICK_HALF clocks; drive_out=1 on the first KICK cycle.
  - After KICK_CYCLES full periods, at the end of the last low half, go to TRACK.
  - pll_enable=1 throughout KICK so the PLL pulls in from its preload.
- TRACK:
  - drive_out <= pll_out (1 clk latency).
  - Watchdog clears on TRACK entry and on every detected feedback edge, otherwise increments.
  - Watchdog reaching FB_TIMEOUT: next state FAULT.
- Burst counter:
  - Counts every cycle in KICK and TRACK.
  - STOP is entered exactly burst_len cycles after KICK entry, which may happen while still in KICK.
- abort=1 in KICK or TRACK: STOP next cycle.
- Same-cycle priority: FAULT > abort = burst expiry.
- STOP:
  - drive_out keeps following the active source (internal or pll_out) until it is 0, then is held 0.
  - The cycle drive_out is 0, go to DONE.
  - The watchdog stays armed; timeout in STOP still faults.
- DONE: done=1 for one cycle, pll_enable=0, next IDLE.
- FAULT:
  - drive_out=0, pll_enable=0, fault=1; start and abort are ignored.
  - fault_clr=1 returns to IDLE next cycle with fault=0.
  - fault_clr is ignored in other states.
- start held high after DONE: a new burst begins on the first IDLE cycle; no self-retrigger inside a burst.
- pll_enable: 1 in KICK, TRACK and STOP; 0 otherwise.

Test Plan (KICK_HALF=10, KICK_CYCLES=2, FB_TIMEOUT=50, BURST_W=16):
- Reset release, start pulse at cycle T, burst_len=200, feedback toggling every 10 clk.
  - KICK at T+1 with pll_load=1 for 1 cycle.
  - drive_out high T+1..T+10 and T+21..T+30.
  - TRACK at T+41.
  - STOP at T+201, then DONE, done pulse, IDLE; fault stays 0.
- start at T with burst_len=15: STOP at T+16 while drive_out is low, so DONE at T+17.
- TRACK with feedback held low:
  - FAULT exactly 50 cycles after TRACK entry; drive_out=0, fault=1.
  - start is ignored.
  - fault_clr returns to IDLE with fault=0.
- abort at T+50 while pll_out is high: drive_out stays high until pll_out falls, then DONE; busy clears after the done pulse.
- rst_n low mid-TRACK with drive_out=1: drive_out=0 without a clk edge, state=0; burst_len=0 with start produces no activity.
- Fault timeout coincident with burst expiry in the same cycle: FAULT wins and no done pulse occurs.

Source files
------------

// File: rtl/qcw_burst_sequencer_if.sv
// Control, status and PLL/gate-drive signals of the QCW burst sequencer.
// The sequencer binds to the slave modport; the trigger/PLL side binds to master.
interface qcw_burst_sequencer_if #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned BURST_W = 24
);
  logic               start;
  logic [BURST_W-1:0] burst_len;
  logic               abort;
  logic               fault_clr;
  logic               feedback_in;
  logic               pll_out;
  logic               pll_enable;
  logic               pll_load;
  logic [CNT_W-1:0]   pll_period;
  logic               drive_out;
  logic               busy;
  logic               done;
  logic               fault;
  logic [2:0]         state;

  modport master (
    output start, burst_len, abort, fault_clr, feedback_in, pll_out,
    input  pll_enable, pll_load, pll_period, drive_out, busy, done, fault, state
  );

  modport slave (
    input  start, burst_len, abort, fault_clr, feedback_in, pll_out,
    output pll_enable, pll_load, pll_period, drive_out, busy, done, fault, state
  );
endinterface

// File: rtl/qcw_burst_sequencer.sv
// One QCW burst: open-loop kick, hand-off to PLL tracking with a feedback-loss
// watchdog, then a stop on a low drive edge. Owns gate drive select and fault latch.
module qcw_burst_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned BURST_W     = 24,
  parameter int unsigned KICK_HALF   = 350,
  parameter int unsigned KICK_CYCLES = 4,
  parameter int unsigned FB_TIMEOUT  = 2000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  qcw_burst_sequencer_if.slave        bus
);

  localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(KICK_HALF - 1);
  localparam logic [CNT_W-1:0]   KICK_LAST = CNT_W'(KICK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   WD_LIMIT  = CNT_W'(FB_TIMEOUT);
  localparam logic [CNT_W-1:0]   PERIOD    = CNT_W'(2 * KICK_HALF);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KICK  = 3'd1,
    S_TRACK = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic [CNT_W-1:0]   kick_q, kick_d;
  logic [CNT_W-1:0]   wd_q, wd_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic               phase_q, phase_d;
  logic               src_pll_q, src_pll_d;
  logic               fb_s1_q, fb_s1_d;
  logic               fb_s2_q, fb_s2_d;
  logic               fb_s3_q, fb_s3_d;
  logic               drive_q, drive_d;
  logic               load_q, load_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;

  logic fb_edge;
  logic wd_hit;
  logic burst_exp;
  logic kick_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      half_q    <= '0;
      kick_q    <= '0;
      wd_q      <= '0;
      burst_q   <= '0;
      len_q     <= '0;
      phase_q   <= 1'b0;
      src_pll_q <= 1'b0;
      fb_s1_q   <= 1'b0;
      fb_s2_q   <= 1'b0;
      fb_s3_q   <= 1'b0;
      drive_q   <= 1'b0;
      load_q    <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      kick_q    <= kick_d;
      wd_q      <= wd_d;
      burst_q   <= burst_d;
      len_q     <= len_d;
      phase_q   <= phase_d;
      src_pll_q <= src_pll_d;
      fb_s1_q   <= fb_s1_d;
      fb_s2_q   <= fb_s2_d;
      fb_s3_q   <= fb_s3_d;
      drive_q   <= drive_d;
      load_q    <= load_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    kick_d    = kick_q;
    wd_d      = wd_q;
    burst_d   = burst_q;
    len_d     = len_q;
    phase_d   = phase_q;
    src_pll_d = src_pll_q;
    drive_d   = 1'b0;
    load_d    = 1'b0;
    wd_hit    = 1'b0;

    // feedback_in is asynchronous: two sync stages, third stage for edge detect
    fb_s1_d = bus.feedback_in;
    fb_s2_d = fb_s1_q;
    fb_s3_d = fb_s2_q;
    fb_edge = fb_s2_q & ~fb_s3_q;

    // internal open-loop source keeps running into STOP when no hand-off happened
    kick_end = 1'b0;
    if (state_q == S_KICK || (state_q == S_STOP && !src_pll_q)) begin
      if (half_q == HALF_LAST) begin
        half_d  = '0;
        phase_d = ~phase_q;
        if (!phase_q) begin
          kick_d   = kick_q + CNT_W'(1);
          kick_end = (kick_q == KICK_LAST);
        end
      end else begin
        half_d = half_q + CNT_W'(1);
      end
    end

    if (state_q == S_TRACK || (state_q == S_STOP && src_pll_q)) begin
      wd_d   = fb_edge ? '0 : wd_q + CNT_W'(1);
      wd_hit = (wd_d == WD_LIMIT);
    end

    burst_exp = (burst_q == len_q - BURST_ONE);
    if (state_q == S_KICK || state_q == S_TRACK) begin
      burst_d = burst_q + BURST_ONE;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && bus.burst_len != '0) begin
          state_d   = S_KICK;
          len_d     = bus.burst_len;
          burst_d   = '0;
          half_d    = '0;
          kick_d    = '0;
          wd_d      = '0;
          phase_d   = 1'b1;
          src_pll_d = 1'b0;
          load_d    = 1'b1;
        end
      end
      S_KICK: begin
        if (bus.abort || burst_exp) begin
          state_d = S_STOP;
        end else if (kick_end) begin
          state_d   = S_TRACK;
          src_pll_d = 1'b1;
          wd_d      = '0;
        end
      end
      S_TRACK: begin
        if (wd_hit) begin
          state_d = S_FAULT;
        end else if (bus.abort || burst_exp) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (wd_hit) begin
          state_d = S_FAULT;
        end else if (!drive_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (bus.fault_clr) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // gate drive follows whichever source is active in the state being entered
    unique case (state_d)
      S_KICK:  drive_d = phase_d;
      S_TRACK: drive_d = bus.pll_out;
      S_STOP:  drive_d = src_pll_d ? bus.pll_out : phase_d;
      default: drive_d = 1'b0;
    endcase

    en_d    = (state_d == S_KICK) || (state_d == S_TRACK) || (state_d == S_STOP);
    busy_d  = en_d || (state_d == S_DONE);
    done_d  = (state_d == S_DONE);
    fault_d = (state_d == S_FAULT);
  end

  assign bus.pll_enable = en_q;
  assign bus.pll_load   = load_q;
  assign bus.pll_period = PERIOD;
  assign bus.drive_out  = drive_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.fault      = fault_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_qcw_burst_sequencer.sv
// Scoreboard bench: scenarios queue expected output events (kind, value, cycle);
// a negedge monitor pops and compares each output change the DUT presents.
module tb_qcw_burst_sequencer;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned BURST_W = 16;

  localparam int K_STATE = 0;
  localparam int K_DRIVE = 1;
  localparam int K_BUSY  = 2;
  localparam int K_PEN   = 3;
  localparam int K_FAULT = 4;
  localparam int K_DONE  = 5;
  localparam int K_LOAD  = 6;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   fb_cnt;
  bit   fb_tog;
  bit   mon_en;
  ev_t  exp_q[$];

  logic [2:0] p_state;
  logic       p_drive, p_busy, p_pen, p_fault, p_done, p_load;

  qcw_burst_sequencer_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) ifc ();

  qcw_burst_sequencer #(
    .CNT_W      (CNT_W),
    .BURST_W    (BURST_W),
    .KICK_HALF  (10),
    .KICK_CYCLES(2),
    .FB_TIMEOUT (50)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // feedback comparator model: toggles every 10 clk when enabled, else low
  always @(negedge clk) begin
    if (fb_tog) begin
      if (fb_cnt == 9) begin
        fb_cnt = 0;
        ifc.feedback_in = ~ifc.feedback_in;
      end else begin
        fb_cnt++;
      end
    end else begin
      fb_cnt = 0;
      ifc.feedback_in = 1'b0;
    end
  end

  function automatic string kname(input int k);
    case (k)
      K_STATE: return "state";
      K_DRIVE: return "drive_out";
      K_BUSY:  return "busy";
      K_PEN:   return "pll_enable";
      K_FAULT: return "fault";
      K_DONE:  return "done";
      default: return "pll_load";
    endcase
  endfunction

  task automatic push(input int k, input int v, input int c);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // standard kick sequence for a start accepted in cycle t with a long burst
  task automatic push_kick(input int t);
    push(K_STATE, 1, t + 1);
    push(K_DRIVE, 1, t + 1);
    push(K_BUSY,  1, t + 1);
    push(K_PEN,   1, t + 1);
    push(K_LOAD,  1, t + 1);
    push(K_DRIVE, 0, t + 11);
    push(K_DRIVE, 1, t + 21);
    push(K_DRIVE, 0, t + 31);
    push(K_STATE, 2, t + 41);
  endtask

  task automatic check_ev(input int k, input int v);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_%s: got %0d at cycle %0d, required no event", kname(k), v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v || e.cyc != cyc) begin
        n_err++;
        $display("FAIL ev_%s: got %s=%0d @%0d, required %s=%0d @%0d",
                 kname(e.kind), kname(k), v, cyc, kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ifc.state != p_state)        check_ev(K_STATE, int'(ifc.state));
      if (ifc.drive_out != p_drive)    check_ev(K_DRIVE, int'(ifc.drive_out));
      if (ifc.busy != p_busy)          check_ev(K_BUSY,  int'(ifc.busy));
      if (ifc.pll_enable != p_pen)     check_ev(K_PEN,   int'(ifc.pll_enable));
      if (ifc.fault != p_fault)        check_ev(K_FAULT, int'(ifc.fault));
      if (ifc.done && !p_done)         check_ev(K_DONE,  1);
      if (ifc.pll_load && !p_load)     check_ev(K_LOAD,  1);
      p_state = ifc.state;
      p_drive = ifc.drive_out;
      p_busy  = ifc.busy;
      p_pen   = ifc.pll_enable;
      p_fault = ifc.fault;
      p_done  = ifc.done;
      p_load  = ifc.pll_load;
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic start_burst(input int len, output int t);
    @(negedge clk);
    t = cyc;
    ifc.start     = 1'b1;
    ifc.burst_len = BURST_W'(len);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    int c;
    cyc = 0; n_vec = 0; n_err = 0; fb_tog = 1'b0; mon_en = 1'b0;
    p_state = 3'd0; p_drive = 1'b0; p_busy = 1'b0; p_pen = 1'b0;
    p_fault = 1'b0; p_done = 1'b0; p_load = 1'b0;
    rst_n = 1'b0;
    ifc.start = 1'b0; ifc.burst_len = '0; ifc.abort = 1'b0;
    ifc.fault_clr = 1'b0; ifc.pll_out = 1'b0;
    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state",      int'(ifc.state), 0);
    chk("rst_drive_out",  int'(ifc.drive_out), 0);
    chk("rst_busy",       int'(ifc.busy), 0);
    chk("rst_pll_enable", int'(ifc.pll_enable), 0);
    chk("rst_pll_load",   int'(ifc.pll_load), 0);
    chk("rst_done",       int'(ifc.done), 0);
    chk("rst_fault",      int'(ifc.fault), 0);
    chk("rst_pll_period", int'(ifc.pll_period), 20);
    mon_en = 1'b1;

    // nominal burst of 200 cycles with live feedback
    fb_tog = 1'b1;
    start_burst(200, t);
    push_kick(t);
    push(K_STATE, 3, t + 201);
    push(K_STATE, 4, t + 202);
    push(K_PEN,   0, t + 202);
    push(K_DONE,  1, t + 202);
    push(K_STATE, 0, t + 203);
    push(K_BUSY,  0, t + 203);
    wait_cyc(t + 1);
    ifc.start = 1'b0;
    wait_cyc(t + 210);
    fb_tog = 1'b0;

    // short burst expiring in a low kick half, start held so it re-arms once idle
    start_burst(15, t);
    push(K_STATE, 1, t + 1);  push(K_DRIVE, 1, t + 1);  push(K_BUSY, 1, t + 1);
    push(K_PEN,   1, t + 1);  push(K_LOAD,  1, t + 1);
    push(K_DRIVE, 0, t + 11);
    push(K_STATE, 3, t + 16);
    push(K_STATE, 4, t + 17); push(K_PEN, 0, t + 17);   push(K_DONE, 1, t + 17);
    push(K_STATE, 0, t + 18); push(K_BUSY, 0, t + 18);
    push(K_STATE, 1, t + 19); push(K_DRIVE, 1, t + 19); push(K_BUSY, 1, t + 19);
    push(K_PEN,   1, t + 19); push(K_LOAD,  1, t + 19);
    push(K_DRIVE, 0, t + 29);
    push(K_STATE, 3, t + 34);
    push(K_STATE, 4, t + 35); push(K_PEN, 0, t + 35);   push(K_DONE, 1, t + 35);
    push(K_STATE, 0, t + 36); push(K_BUSY, 0, t + 36);
    wait_cyc(t + 19);
    ifc.start = 1'b0;
    wait_cyc(t + 45);

    // feedback lost in TRACK: fault, start/abort ignored, fault_clr recovers
    start_burst(1000, t);
    push_kick(t);
    push(K_STATE, 5, t + 91); push(K_BUSY, 0, t + 91);
    push(K_PEN,   0, t + 91); push(K_FAULT, 1, t + 91);
    push(K_STATE, 0, t + 101); push(K_FAULT, 0, t + 101);
    wait_cyc(t + 1);
    ifc.start = 1'b0;
    wait_cyc(t + 95);
    ifc.start = 1'b1; ifc.abort = 1'b1;
    wait_cyc(t + 100);
    ifc.start = 1'b0; ifc.abort = 1'b0; ifc.fault_clr = 1'b1;
    wait_cyc(t + 101);
    ifc.fault_clr = 1'b0;
    wait_cyc(t + 110);

    // abort while pll_out is high: drive holds until pll_out falls
    start_burst(1000, t);
    push_kick(t);
    push(K_DRIVE, 1, t + 46);
    push(K_STATE, 3, t + 51);
    push(K_DRIVE, 0, t + 56);
    push(K_STATE, 4, t + 57); push(K_PEN, 0, t + 57); push(K_DONE, 1, t + 57);
    push(K_STATE, 0, t + 58); push(K_BUSY, 0, t + 58);
    wait_cyc(t + 1);
    ifc.start = 1'b0;
    wait_cyc(t + 45); ifc.pll_out = 1'b1;
    wait_cyc(t + 50); ifc.abort = 1'b1;
    wait_cyc(t + 51); ifc.abort = 1'b0;
    wait_cyc(t + 55); ifc.pll_out = 1'b0;
    wait_cyc(t + 65);

    // asynchronous reset mid-TRACK with drive high, then zero-length start
    start_burst(1000, t);
    push_kick(t);
    push(K_DRIVE, 1, t + 44);
    wait_cyc(t + 1);
    ifc.start = 1'b0;
    wait_cyc(t + 43); ifc.pll_out = 1'b1;
    wait_cyc(t + 45);
    @(posedge clk);
    #2;
    c = cyc;
    push(K_STATE, 0, c); push(K_DRIVE, 0, c); push(K_BUSY, 0, c); push(K_PEN, 0, c);
    chk("pre_rst_drive_out", int'(ifc.drive_out), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_drive_out", int'(ifc.drive_out), 0);
    chk("async_rst_state",     int'(ifc.state), 0);
    ifc.pll_out = 1'b0;
    wait_cyc(c + 2);
    rst_n = 1'b1;
    ifc.start = 1'b1; ifc.burst_len = '0;
    wait_cyc(c + 8);
    ifc.start = 1'b0;
    chk("zero_len_state", int'(ifc.state), 0);
    wait_cyc(c + 12);

    // watchdog timeout in the same cycle as burst expiry: fault wins, no done
    start_burst(90, t);
    push_kick(t);
    push(K_STATE, 5, t + 91); push(K_BUSY, 0, t + 91);
    push(K_PEN,   0, t + 91); push(K_FAULT, 1, t + 91);
    push(K_STATE, 0, t + 96); push(K_FAULT, 0, t + 96);
    wait_cyc(t + 1);
    ifc.start = 1'b0;
    wait_cyc(t + 95); ifc.fault_clr = 1'b1;
    wait_cyc(t + 96); ifc.fault_clr = 1'b0;
    wait_cyc(t + 110);

    chk("events_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
